regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (we3/a3/wd3) between REQUESTERS writeback sources (ALU, load unit, multi-cycle units) using round-robin arbitration with a registered output stage. It also keeps a per-register busy scoreboard, set at instruction issue and cleared when the write reaches the register file, which the hazard logic uses to stall readers. It sits between the execute/memory writeback paths and `register_file`.

## Interface
- REGISTERS, 32, number of architectural registers; AW = $clog2(REGISTERS)
- WIDTH, 32, data width
- REQUESTERS, 3, number of writeback sources (2..8)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  REQUESTERS  requester i has a write pending
- req_ready  out  REQUESTERS  grant; one-hot or zero
- req_addr  in  REQUESTERS*AW  destination of requester i, slice [i*AW +: AW]
- req_data  in  REQUESTERS*WIDTH  data of requester i, slice [i*WIDTH +: WIDTH]
- issue_valid  in  1  an instruction with destination issue_addr is issued
- issue_addr  in  AW  destination register being marked busy
- flush  in  1  pipeline flush: clear scoreboard, block grants this cycle
- rf_we  out  1  to register_file we3
- rf_addr  out  AW  to register_file a3
- rf_data  out  WIDTH  to register_file wd3
- busy  out  REGISTERS  bit r = register r has an outstanding write

## Operation
- Handshake: transfer on req_valid[i] && req_ready[i]. req_ready may depend on req_valid; requesters must hold valid/addr/data stable until accepted.
- Arbitration: combinational round-robin. Search starts at (last_grant+1) mod REQUESTERS; first valid requester gets req_ready. At most one grant per cycle. last_grant updates only on a transfer.
- Reset: last_grant = REQUESTERS-1, so requester 0 has highest priority first.
- flush=1: req_ready all 0 this cycle, no transfer, last_grant unchanged.
- Output stage: on transfer, next edge loads rf_addr/rf_data from the winner; rf_we = 1 unless the address is 0 (x0 writes are accepted and discarded, rf_we = 0). No transfer -> rf_we = 0 next cycle; rf_addr/rf_data hold.
- Scoreboard, per edge:
  - issue_valid && issue_addr != 0 -> set busy[issue_addr].
  - rf_we -> clear busy[rf_addr].
  - Same register set and cleared in one cycle -> set wins (the new producer is outstanding).
  - flush -> busy cleared to all 0, overriding issue and clear.
  - busy[0] is constant 0.
- Writes to a register that is not busy are still performed.

## Timing
- Reset values: rf_we=0, rf_addr=0, rf_data=0, busy=0, last_grant=REQUESTERS-1. req_ready is combinational; during reset it is 0.
- Latency: accept at edge N -> rf_we/rf_addr/rf_data valid during cycle N+1 -> register file writes at edge N+1 -> busy bit clear from cycle N+2.
- Throughput: one write per cycle sustained. Each continuously-valid requester is granted at least once every REQUESTERS cycles.
- Reset asserted mid-stream: all state returns to reset values immediately. An in-flight rf_we is dropped. Requesters re-present after reset.

## Test plan
- Reset: assert rst with all req_valid=1 -> rf_we=0, busy=0, req_ready=0. After release with all three valid, the first grant is requester 0.
- Round-robin fairness: requesters 0, 1, 2 held valid (addr 5, 6, 7; data 0xA, 0xB, 0xC) -> grants 0,1,2,0,1,2. rf_we=1 each cycle with matching addr/data one cycle after each grant.
- x0 discard: requester 1 writes addr 0, data 0xDEAD -> req_ready[1]=1, rf_we stays 0 the next cycle, busy unchanged.
- Scoreboard: issue addr 9 -> busy[9]=1 next cycle. Requester 2 writes addr 9 -> rf_we at N+1, busy[9]=0 at N+2. Issue addr 9 in the same cycle rf_we targets 9 -> busy[9] stays 1.
- Flush: busy=0x0000_0F00 with requester 0 valid, assert flush with issue_valid addr 3 -> req_ready=0, busy=0 next cycle, grant resumes the cycle after.
- Reset mid-operation: assert rst while rf_we=1 for addr 4 -> rf_we=0 immediately (asynchronous), busy cleared, arbitration restarts at requester 0.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : regfile_write_arbiter_if
// Purpose  : Bundles the writeback request bus, the issue/flush inputs and
//            the register-file write port of regfile_write_arbiter.
// Ports    : req_valid/req_ready/req_addr/req_data  writeback handshake
//            issue_valid/issue_addr                 busy-mark at issue
//            flush                                  pipeline flush
//            rf_we/rf_addr/rf_data                  register_file write port
//            busy                                   per-register scoreboard
// Modports : master = writeback sources / pipeline side
//            slave  = arbiter side
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int REGISTERS  = 32,
    parameter int WIDTH      = 32,
    parameter int REQUESTERS = 3,
    parameter int AW         = $clog2(REGISTERS)
) ();
    logic [REQUESTERS-1:0]       req_valid;
    logic [REQUESTERS-1:0]       req_ready;
    logic [REQUESTERS*AW-1:0]    req_addr;
    logic [REQUESTERS*WIDTH-1:0] req_data;
    logic                        issue_valid;
    logic [AW-1:0]               issue_addr;
    logic                        flush;
    logic                        rf_we;
    logic [AW-1:0]               rf_addr;
    logic [WIDTH-1:0]            rf_data;
    logic [REGISTERS-1:0]        busy;

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_addr, flush,
        input  req_ready, rf_we, rf_addr, rf_data, busy
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_addr, flush,
        output req_ready, rf_we, rf_addr, rf_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : regfile_write_arbiter
// Purpose  : Round-robin arbiter sharing the single register-file write port
//            between REQUESTERS writeback sources, with a registered output
//            stage and a per-register busy scoreboard for hazard stalls.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - regfile_write_arbiter_if.slave (requests, issue, flush,
//                   register-file write port, busy vector)
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int REGISTERS  = 32,
    parameter int WIDTH      = 32,
    parameter int REQUESTERS = 3
) (
    input  wire logic             clk,
    input  wire logic             rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int AW   = $clog2(REGISTERS);
    localparam int IDXW = $clog2(REQUESTERS);
    localparam logic [IDXW-1:0] c_last_rst = IDXW'(REQUESTERS - 1);

    // Per-requester views of the flattened address/data buses
    logic [AW-1:0]    w_addr [REQUESTERS];
    logic [WIDTH-1:0] w_data [REQUESTERS];

    generate
        for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
            assign w_addr[gi] = bus.req_addr[gi*AW +: AW];
            assign w_data[gi] = bus.req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic [IDXW-1:0]       r_last_grant;
    logic                  r_rf_we;
    logic [AW-1:0]         r_rf_addr;
    logic [WIDTH-1:0]      r_rf_data;
    logic [REGISTERS-1:0]  r_busy;

    logic [REQUESTERS-1:0] w_grant;
    logic [IDXW-1:0]       w_win_idx;
    logic [IDXW-1:0]       w_cand;
    logic                  w_found;
    logic                  w_xfer;
    logic [REGISTERS-1:0]  w_busy_next;

    // Round-robin search: candidates are visited starting one past the last
    // winner and wrapping, so the previous winner has lowest priority.
    always_comb begin
        w_grant   = '0;
        w_win_idx = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            w_cand = IDXW'((int'(r_last_grant) + k) % REQUESTERS);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand;
            end
        end
        // No grant while flushing, and none while held in reset
        if (bus.flush || rst) begin
            w_found = 1'b0;
        end
        if (w_found) begin
            w_grant[w_win_idx] = 1'b1;
        end
    end

    assign w_xfer        = w_found;
    assign bus.req_ready = w_grant;

    // Scoreboard update order matters: clear first, then set so that a new
    // producer issued in the same cycle as the old one retires stays busy,
    // then flush overrides everything. Register 0 is never busy.
    always_comb begin
        w_busy_next = r_busy;
        if (r_rf_we) begin
            w_busy_next[r_rf_addr] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_addr != '0)) begin
            w_busy_next[bus.issue_addr] = 1'b1;
        end
        if (bus.flush) begin
            w_busy_next = '0;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_last_rst;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
            r_busy       <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_xfer) begin
                r_last_grant <= w_win_idx;
                r_rf_addr    <= w_addr[w_win_idx];
                r_rf_data    <= w_data[w_win_idx];
                // x0 writes are accepted but never reach the register file
                r_rf_we      <= (w_addr[w_win_idx] != '0);
            end else begin
                r_rf_we <= 1'b0;
            end
        end
    end

    assign bus.rf_we   = r_rf_we;
    assign bus.rf_addr = r_rf_addr;
    assign bus.rf_data = r_rf_data;
    assign bus.busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
//----------------------------------------------------------------------------
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed self-checking bench for regfile_write_arbiter.
// Revision : 1.0  initial release
//----------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    localparam int REGISTERS  = 32;
    localparam int WIDTH      = 32;
    localparam int REQUESTERS = 3;
    localparam int AW         = 5;

    logic clk;
    logic rst;

    regfile_write_arbiter_if #(
        .REGISTERS  (REGISTERS),
        .WIDTH      (WIDTH),
        .REQUESTERS (REQUESTERS),
        .AW         (AW)
    ) bus_if ();

    regfile_write_arbiter #(
        .REGISTERS  (REGISTERS),
        .WIDTH      (WIDTH),
        .REQUESTERS (REQUESTERS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       t_valid;
    logic [AW-1:0]    t_addr [3];
    logic [WIDTH-1:0] t_data [3];

    always_comb begin
        bus_if.req_valid = t_valid;
        bus_if.req_addr  = {t_addr[2], t_addr[1], t_addr[0]};
        bus_if.req_data  = {t_data[2], t_data[1], t_data[0]};
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 2 units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic [1:0] i, input logic v,
                           input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        t_valid[i] = v;
        t_addr[i]  = a;
        t_data[i]  = d;
    endtask

    initial begin
        rst                = 1'b1;
        t_valid            = 3'b000;
        bus_if.issue_valid = 1'b0;
        bus_if.issue_addr  = '0;
        bus_if.flush       = 1'b0;
        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'hB);
        set_req(2, 1'b1, 5'd7, 32'hC);

        // Reset held with everyone valid
        step();
        step();
        check("rst_rf_we", 64'(bus_if.rf_we), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_ready", 64'(bus_if.req_ready), 64'd0);
        check("rst_rf_addr", 64'(bus_if.rf_addr), 64'd0);

        // Release and watch round-robin 0,1,2,0,1,2
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_ready", 64'(bus_if.req_ready), 64'(3'b001 << (i % 3)));
            if (i > 0) begin
                check("rr_we", 64'(bus_if.rf_we), 64'd1);
                check("rr_addr", 64'(bus_if.rf_addr), 64'(5 + (i - 1) % 3));
                check("rr_data", 64'(bus_if.rf_data), 64'(32'hA + (i - 1) % 3));
            end
            step();
            #1;
        end
        check("rr_last_addr", 64'(bus_if.rf_addr), 64'd7);
        check("rr_last_data", 64'(bus_if.rf_data), 64'hC);
        t_valid = 3'b000;
        #1;
        check("idle_ready", 64'(bus_if.req_ready), 64'd0);
        step();
        check("idle_we", 64'(bus_if.rf_we), 64'd0);

        // x0 write from requester 1 is accepted then discarded
        set_req(1, 1'b1, 5'd0, 32'hDEAD);
        #1;
        check("x0_ready", 64'(bus_if.req_ready), 64'b010);
        step();
        t_valid = 3'b000;
        check("x0_we", 64'(bus_if.rf_we), 64'd0);
        check("x0_data", 64'(bus_if.rf_data), 64'hDEAD);
        check("x0_busy", 64'(bus_if.busy), 64'd0);

        // Scoreboard set at issue, cleared after the write lands
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd9;
        step();
        bus_if.issue_valid = 1'b0;
        check("sb_set", 64'(bus_if.busy), 64'h200);
        set_req(2, 1'b1, 5'd9, 32'h99);
        #1;
        check("sb_ready", 64'(bus_if.req_ready), 64'b100);
        step();
        t_valid = 3'b000;
        check("sb_we", 64'(bus_if.rf_we), 64'd1);
        check("sb_addr", 64'(bus_if.rf_addr), 64'd9);
        check("sb_busy_n1", 64'(bus_if.busy), 64'h200);
        step();
        check("sb_busy_n2", 64'(bus_if.busy), 64'd0);

        // Issue to 9 in the same cycle the write to 9 retires: stays busy
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd9;
        step();
        bus_if.issue_valid = 1'b0;
        set_req(2, 1'b1, 5'd9, 32'h98);
        step();
        t_valid = 3'b000;
        check("sw_we", 64'(bus_if.rf_we), 64'd1);
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd9;
        step();
        bus_if.issue_valid = 1'b0;
        check("set_wins", 64'(bus_if.busy), 64'h200);

        // Build busy = 0xF00, then flush with an issue and a valid request
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd8;
        step();
        bus_if.issue_addr  = 5'd10;
        step();
        bus_if.issue_addr  = 5'd11;
        step();
        bus_if.issue_valid = 1'b0;
        check("fl_pre_busy", 64'(bus_if.busy), 64'hF00);
        set_req(0, 1'b1, 5'd3, 32'h33);
        bus_if.flush       = 1'b1;
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd3;
        #1;
        check("fl_ready", 64'(bus_if.req_ready), 64'd0);
        step();
        bus_if.flush       = 1'b0;
        bus_if.issue_valid = 1'b0;
        #1;
        check("fl_busy", 64'(bus_if.busy), 64'd0);
        check("fl_we", 64'(bus_if.rf_we), 64'd0);
        check("fl_resume", 64'(bus_if.req_ready), 64'b001);
        step();
        t_valid = 3'b000;
        check("fl_post_we", 64'(bus_if.rf_we), 64'd1);
        check("fl_post_addr", 64'(bus_if.rf_addr), 64'd3);

        // Reset mid-stream while a write to x4 is on the port
        set_req(0, 1'b1, 5'd4, 32'h44);
        bus_if.issue_valid = 1'b1;
        bus_if.issue_addr  = 5'd4;
        step();
        t_valid            = 3'b000;
        bus_if.issue_valid = 1'b0;
        check("mr_we_pre", 64'(bus_if.rf_we), 64'd1);
        check("mr_busy_pre", 64'(bus_if.busy), 64'h10);
        rst = 1'b1;
        #1;
        check("mr_we", 64'(bus_if.rf_we), 64'd0);
        check("mr_busy", 64'(bus_if.busy), 64'd0);
        set_req(0, 1'b1, 5'd5, 32'hA);
        set_req(1, 1'b1, 5'd6, 32'hB);
        set_req(2, 1'b1, 5'd7, 32'hC);
        #1;
        check("mr_ready", 64'(bus_if.req_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("mr_restart", 64'(bus_if.req_ready), 64'b001);
        step();
        check("mr_first_addr", 64'(bus_if.rf_addr), 64'd5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
